// File: rtl/corr_search_xor_if.sv
`default_nettype none
// ============================================================================
// Module  : corr_search_xor_if
// Purpose : Control, BRAM read and result bundle for the XOR correlator.
// Rev     : 1.0  initial release
// ============================================================================
interface corr_search_xor_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 9,
    parameter int OFF_W  = 6,
    parameter int SUM_W  = 16
);
    logic              go;
    logic              mode;
    logic [OFF_W-1:0]  x_offset;
    logic [OFF_W-1:0]  y_offset;
    logic              curr_frame_bram_offset_sel;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              busy;
    logic              done;
    logic [OFF_W-1:0]  best_dx;
    logic [OFF_W-1:0]  best_dy;
    logic [SUM_W-1:0]  corr_sum;

    modport master (
        output go, mode, x_offset, y_offset, curr_frame_bram_offset_sel, bram_data,
        input  bram_addr, busy, done, best_dx, best_dy, corr_sum
    );

    modport slave (
        input  go, mode, x_offset, y_offset, curr_frame_bram_offset_sel, bram_data,
        output bram_addr, busy, done, best_dx, best_dy, corr_sum
    );
endinterface
`default_nettype wire

// File: rtl/corr_search_xor.sv
`default_nettype none
// ============================================================================
// Module  : corr_search_xor
// Purpose : XOR/popcount edge-map correlator, single offset or full window search.
// Rev     : 1.0  initial release
// ============================================================================
module corr_search_xor #(
    parameter int DATA_W       = 128,
    parameter int ADDR_W       = 9,
    parameter int FRAME_STRIDE = 256,
    parameter int ROWS         = 32,
    parameter int WIN_W        = 32,
    parameter int SEARCH_R     = 4,
    parameter int OFF_W        = 6,
    parameter int SUM_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    corr_search_xor_if.slave bus
);

    localparam int CNT_W = $clog2(2*ROWS+1);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [OFF_W-1:0]  c_max_off    = OFF_W'(2*SEARCH_R);
    localparam logic [CNT_W-1:0]  c_last_cnt   = CNT_W'(2*ROWS);
    localparam logic [CNT_W-1:0]  c_last_fetch = CNT_W'(2*ROWS-1);
    localparam logic [ADDR_W-1:0] c_stride     = ADDR_W'(FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] c_r_addr     = ADDR_W'(SEARCH_R);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_cmp  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mode;
    logic              r_sel;
    logic [OFF_W-1:0]  r_dx;
    logic [OFF_W-1:0]  r_dy;
    logic [WIN_W-1:0]  r_ref;
    logic [SUM_W-1:0]  r_acc;
    logic              r_first;
    logic [SUM_W-1:0]  r_best_sum;
    logic [OFF_W-1:0]  r_best_dx;
    logic [OFF_W-1:0]  r_best_dy;
    logic [SUM_W-1:0]  r_out_sum;
    logic [OFF_W-1:0]  r_out_dx;
    logic [OFF_W-1:0]  r_out_dy;

    logic              w_busy;
    logic              w_done;
    logic              w_start;
    logic              w_in_run;
    logic              w_in_cmp;
    logic              w_last_off;

    logic [OFF_W-1:0]  w_x_clamp;
    logic [OFF_W-1:0]  w_y_clamp;
    logic [ADDR_W-1:0] w_ref_base;
    logic [ADDR_W-1:0] w_cur_base;
    logic [ADDR_W-1:0] w_start_addr;
    logic [CNT_W-1:0]  w_n;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_next_addr;
    logic [WIN_W-1:0]  w_cur_win;
    logic [SUM_W:0]    w_pop;
    logic [SUM_W:0]    w_sum_ext;
    logic [SUM_W-1:0]  w_acc_next;
    logic              w_take;
    logic [SUM_W-1:0]  w_nb_sum;
    logic [OFF_W-1:0]  w_nb_dx;
    logic [OFF_W-1:0]  w_nb_dy;

    function automatic logic [SUM_W:0] popcount(input logic [WIN_W-1:0] v);
        logic [SUM_W:0] c;
        c = '0;
        for (int i = 0; i < WIN_W; i++) begin
            c = c + {{SUM_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (bus.go) w_next_state = c_run;
            c_run:   if (r_cnt == c_last_cnt) w_next_state = c_cmp;
            c_cmp:   w_next_state = w_last_off ? c_done : c_run;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_start  = 1'b0;
        w_in_run = 1'b0;
        w_in_cmp = 1'b0;
        case (r_state)
            c_idle:  w_start = bus.go;
            c_run:   begin w_busy = 1'b1; w_in_run = 1'b1; end
            c_cmp:   begin w_busy = 1'b1; w_in_cmp = 1'b1; end
            c_done:  w_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath combinational ----------------
    assign w_x_clamp    = (bus.x_offset > c_max_off) ? c_max_off : bus.x_offset;
    assign w_y_clamp    = (bus.y_offset > c_max_off) ? c_max_off : bus.y_offset;
    assign w_ref_base   = r_sel ? '0 : c_stride;
    assign w_cur_base   = r_sel ? c_stride : '0;
    assign w_start_addr = (bus.curr_frame_bram_offset_sel ? '0 : c_stride) + c_r_addr;

    // Odd fetch slots read the current frame, even slots the reference frame.
    assign w_n         = r_cnt + CNT_W'(1);
    assign w_row       = ADDR_W'(w_n >> 1);
    assign w_next_addr = w_n[0] ? (w_cur_base + ADDR_W'(r_dy) + w_row)
                                : (w_ref_base + c_r_addr + w_row);

    assign w_cur_win  = bus.bram_data[IDX_W'(r_dx) +: WIN_W];
    assign w_pop      = popcount(r_ref ^ w_cur_win);
    assign w_sum_ext  = {1'b0, r_acc} + w_pop;
    assign w_acc_next = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];

    assign w_last_off = !r_mode || ((r_dx == c_max_off) && (r_dy == c_max_off));

    // Strict compare keeps the earliest offset on ties.
    assign w_take   = r_first || (r_acc < r_best_sum);
    assign w_nb_sum = w_take ? r_acc : r_best_sum;
    assign w_nb_dx  = w_take ? r_dx  : r_best_dx;
    assign w_nb_dy  = w_take ? r_dy  : r_best_dy;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_mode     <= 1'b0;
            r_sel      <= 1'b0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_ref      <= '0;
            r_acc      <= '0;
            r_first    <= 1'b0;
            r_best_sum <= '0;
            r_best_dx  <= '0;
            r_best_dy  <= '0;
            r_out_sum  <= '0;
            r_out_dx   <= '0;
            r_out_dy   <= '0;
        end else if (w_start) begin
            r_mode  <= bus.mode;
            r_sel   <= bus.curr_frame_bram_offset_sel;
            r_dx    <= bus.mode ? '0 : w_x_clamp;
            r_dy    <= bus.mode ? '0 : w_y_clamp;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_first <= 1'b1;
            r_addr  <= w_start_addr;
        end else if (w_in_run) begin
            r_cnt <= w_n;
            if (r_cnt < c_last_fetch) begin
                r_addr <= w_next_addr;
            end
            if (r_cnt[0]) begin
                r_ref <= bus.bram_data[SEARCH_R +: WIN_W];
            end else if (r_cnt != '0) begin
                r_acc <= w_acc_next;
            end
        end else if (w_in_cmp) begin
            r_first    <= 1'b0;
            r_best_sum <= w_nb_sum;
            r_best_dx  <= w_nb_dx;
            r_best_dy  <= w_nb_dy;
            if (w_last_off) begin
                r_out_sum <= w_nb_sum;
                r_out_dx  <= w_nb_dx;
                r_out_dy  <= w_nb_dy;
            end else begin
                // Raster order: dx inner, dy outer.
                if (r_dx == c_max_off) begin
                    r_dx <= '0;
                    r_dy <= r_dy + OFF_W'(1);
                end else begin
                    r_dx <= r_dx + OFF_W'(1);
                end
                r_cnt  <= '0;
                r_acc  <= '0;
                r_addr <= w_ref_base + c_r_addr;
            end
        end
    end

    assign bus.bram_addr = r_addr;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.best_dx   = r_out_dx;
    assign bus.best_dy   = r_out_dy;
    assign bus.corr_sum  = r_out_sum;

endmodule
`default_nettype wire

// File: doc/corr_search_xor.md
Name: corr_search_xor

Overview:
- Parametrised XOR/popcount motion correlator for the stabilisation path.
- Frames are 1-bit-per-pixel edge maps; each row is one BRAM word, and both frames live in one BRAM.
- Either evaluates one supplied (x,y) offset (single mode) or sweeps the full (2R+1)^2 offset window (search mode).
- In search mode it reports the minimum-mismatch offset and its sum, for the motion estimator/stabiliser controller downstream.

Parameters:
- DATA_W, 128: pixels per BRAM word/row.
- ADDR_W, 9: BRAM address width.
- FRAME_STRIDE, 256: word offset between frame 0 and frame 1.
- ROWS, 32: rows compared per offset.
- WIN_W, 32: pixels compared per row.
- SEARCH_R, 4: search radius; offsets 0..2R, with R meaning zero motion.
- OFF_W, 6: width of offset ports.
- SUM_W, 16: correlation sum width.
- Legal configuration: WIN_W+2R <= DATA_W and ROWS+2R <= FRAME_STRIDE.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  start request, sampled only in IDLE
- mode  in  1  0 = single offset, 1 = full search
- x_offset  in  OFF_W  single-mode dx, unsigned
- y_offset  in  OFF_W  single-mode dy, unsigned
- curr_frame_bram_offset_sel  in  1  0: current frame at base 0, reference at FRAME_STRIDE; 1: swapped
- bram_addr  out  ADDR_W  BRAM read address (registered)
- bram_data  in  DATA_W  BRAM read data, valid 1 cycle after address
- busy  out  1  high from the cycle after an accepted go until done
- done  out  1  one-cycle pulse when results are valid
- best_dx  out  OFF_W  winning dx
- best_dy  out  OFF_W  winning dy
- corr_sum  out  SUM_W  mismatch count at the winning offset

Behaviour:
- Reset (async, active-high): state=IDLE; bram_addr, busy, done, best_dx, best_dy and corr_sum all go to 0.
  - Asserting reset mid-operation aborts the operation; no done is generated.
- Start: on go=1 in IDLE, latch mode, sel, x_offset and y_offset.
  - x_offset or y_offset greater than 2R is clamped to 2R.
  - go while busy is ignored.
- States: IDLE -> RUN -> CMP -> (next offset: RUN | finished: DONE) -> IDLE.
- Per-row address sequence for row r = 0..ROWS-1 at offset (dx,dy):
  - cycle 2r: bram_addr = ref_base + R + r.
  - cycle 2r+1: bram_addr = cur_base + dy + r; ref word registered.
  - cycle 2r+2: cur word arrives; acc += popcount(ref[R +: WIN_W] XOR cur[dx +: WIN_W]).
- Bit 0 of a word is the leftmost pixel. Rows are pipelined, so row r+1's ref fetch overlaps row r's accumulate.
- Accumulator:
  - cleared at the start of each offset.
  - width SUM_W, saturating at 2^SUM_W-1; no wrap.
- CMP, one cycle per offset:
  - On the first offset, or when acc < best_sum (strict), update best_sum, best_dx and best_dy.
  - Ties keep the earlier offset.
- Timing:
  - Per offset: exactly 2*ROWS+2 cycles (RUN plus CMP).
  - Scan order in search mode: dy outer 0..2R, dx inner 0..2R, both ascending.
  - Single mode: exactly one offset, evaluated at the clamped inputs.
- DONE (1 cycle):
  - done=1; corr_sum, best_dx and best_dy updated; busy falls in the same cycle.
  - Results hold until the next accepted go.
  - go is accepted again on the cycle after DONE.
- Results during operation:
  - Outputs keep their previous values while busy; partial results are never visible.
  - A new accepted go does not clear the outputs until its own DONE.
- Latency from go:
  - Single mode: done at cycle 2*ROWS+3.
  - Search mode: done at cycle (2R+1)^2*(2*ROWS+2)+1. With the defaults this is 81*66+1 = 5347.
- bram_addr wraps modulo 2^ADDR_W. This cannot occur under the legal configuration constraints.

Test Plan:
- Identical frames, random content, mode=1 -> best_dx=4, best_dy=4, corr_sum=0; done exactly 5347 cycles after go.
- Current frame = reference shifted +2 px right and +1 row down, mode=1 -> best_dx=6, best_dy=5, corr_sum=0.
- Reference all ones, current all zeros, mode=0, x=y=3 -> corr_sum=1024, best=(3,3), done at cycle 67.
- Both frames uniform zero, mode=1 -> all sums tie; best=(0,0), corr_sum=0. Then single mode with x_offset=63 -> clamped, best_dx=8.
- curr_frame_bram_offset_sel=1 with frames swapped in BRAM -> same results as sel=0 on the unswapped image; bram_addr observed in both halves accordingly.
- go pulsed while busy has no effect; reset asserted at cycle 1000 of a search -> outputs 0 immediately, no done; a new go then completes normally.
